sum_collector: RTL and testbench

SUM_COLLECTOR -- requirements
Module: sum_collector

---
 rtl/sum_pkg.sv | 11 +
 rtl/sum_fifo.sv | 79 +++++++
 rtl/sum_collector.sv | 75 +++++++
 tb/tb_sum_collector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the sum collector: word width, default sizing and
// the sum word type used by the FIFO and the collector top.
package sum_pkg;

  localparam int SUM_W         = 9;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_ACC_W = 16;

  typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/sum_fifo.sv
// First-word-fall-through FIFO for sum words.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_valid        upstream word offered (no backpressure)
//   wr_data         upstream word
//   wr_accept       word is stored this cycle
//   full            FIFO holds DEPTH words
//   rd_ready        consumer takes the head word this cycle
//   rd_data         head word (don't-care when rd_valid=0)
//   rd_valid        FIFO not empty
//   rd_fire         head word leaves this cycle
//   level           occupancy 0..DEPTH
module sum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_accept,
  output logic             full,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_fire,
  output logic [LVL_W-1:0] level
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    full      = (level_q == LVL_FULL);
    rd_valid  = (level_q != '0);
    rd_data   = mem_q[rd_ptr_q];
    rd_fire   = rd_valid && rd_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    wr_accept = wr_valid && (!full || rd_fire);
    level     = level_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_accept, rd_fire})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; an empty level makes stale words invisible.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sum_collector.sv
// Collects sum words from the adder stage into a FWFT FIFO and keeps a
// running total of every word the consumer pops.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_sum      sum word, qualified by in_valid (never backpressured)
//   out_data    head-of-FIFO word, valid when out_valid
//   out_ready   consumer accepts out_data
//   acc_clr     synchronous clear of acc_total and overflow
//   acc_total   modulo-2^ACC_W sum of popped words
//   level       FIFO occupancy
//   overflow    sticky: a word was dropped while full
module sum_collector
  import sum_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  sum_t                       in_sum,
  input  logic                       in_valid,
  output sum_t                       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       acc_clr,
  output logic [ACC_W-1:0]           acc_total,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  logic             wr_accept, full, pop;
  logic [ACC_W-1:0] acc_total_q, acc_total_d;
  logic             overflow_q, overflow_d;

  sum_fifo #(.DEPTH(DEPTH), .WIDTH(SUM_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (in_valid),
    .wr_data   (in_sum),
    .wr_accept (wr_accept),
    .full      (full),
    .rd_ready  (out_ready),
    .rd_data   (out_data),
    .rd_valid  (out_valid),
    .rd_fire   (pop),
    .level     (level)
  );

  always_comb begin
    acc_total_d = acc_total_q;
    overflow_d  = overflow_q;
    // Clear wins over a same-cycle pop: the word leaves but is not summed.
    if (acc_clr) begin
      acc_total_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (pop) acc_total_d = acc_total_q + ACC_W'(out_data);
      if (in_valid && !wr_accept) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_total_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      acc_total_q <= acc_total_d;
      overflow_q  <= overflow_d;
    end
  end

  assign acc_total = acc_total_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sum_collector.sv
module tb_sum_collector;
  import sum_pkg::*;

  localparam int DEPTH = 4;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  sum_t             in_sum;
  logic             in_valid;
  sum_t             out_data;
  logic             out_valid;
  logic             out_ready;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_total;
  logic [2:0]       level;
  logic             overflow;

  int checks   = 0;
  int failures = 0;
  sum_t exp_q[$];

  sum_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sum    (in_sum),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_clr   (acc_clr),
    .acc_total (acc_total),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT is about to perform is compared to the
  // oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(out_data), 32'h0DEAD);
      end else begin
        chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input sum_t d, input bit accepted);
    in_valid = 1'b1;
    in_sum   = d;
    if (accepted) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_sum = '0; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_acc", 32'(acc_total), 0);
    chk("rst_overflow", 32'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, no bypass in the push cycle.
    in_valid = 1'b1; in_sum = 9'h1FF;
    #1 chk("no_bypass_valid", 32'(out_valid), 0);
    exp_q.push_back(9'h1FF);
    step();
    in_valid = 1'b0;
    chk("first_valid", 32'(out_valid), 1);
    chk("first_data", 32'(out_data), 32'h1FF);
    chk("first_level", 32'(level), 1);
    step();
    chk("hold_data", 32'(out_data), 32'h1FF);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("acc_1ff", 32'(acc_total), 32'h1FF);
    chk("level_empty", 32'(level), 0);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    chk("clr_acc", 32'(acc_total), 0);

    // 3, 5, 7 then drain.
    push(9'd3, 1); push(9'd5, 1); push(9'd7, 1);
    chk("lvl3", 32'(level), 3);
    out_ready = 1'b1; repeat (3) step(); out_ready = 1'b0;
    chk("acc_15", 32'(acc_total), 15);
    chk("lvl0_after_drain", 32'(level), 0);

    // Fill, then a dropped word.
    push(9'd1, 1); push(9'd2, 1); push(9'd3, 1); push(9'd4, 1);
    chk("lvl_full", 32'(level), 4);
    chk("no_ovf_yet", 32'(overflow), 0);
    push(9'h0AA, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("lvl_full_after_drop", 32'(level), 4);

    // Full with simultaneous push and pop.
    in_valid = 1'b1; in_sum = 9'h011; out_ready = 1'b1;
    exp_q.push_back(9'h011);
    step();
    in_valid = 1'b0;
    chk("lvl_full_pushpop", 32'(level), 4);
    repeat (4) step();
    out_ready = 1'b0;
    chk("lvl0_after_full", 32'(level), 0);
    chk("acc_42", 32'(acc_total), 15 + 1 + 2 + 3 + 4 + 17);
    chk("ovf_sticky", 32'(overflow), 1);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    chk("acc_clr2", 32'(acc_total), 0);

    // 129 pops of 0x1FF; total wraps modulo 2^16.
    in_valid = 1'b1; in_sum = 9'h1FF; out_ready = 1'b1;
    for (int i = 0; i < 129; i++) begin
      exp_q.push_back(9'h1FF);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("acc_wrap", 32'(acc_total), (129 * 511) % 65536);
    chk("lvl0_after_wrap", 32'(level), 0);
    chk("no_ovf_stream", 32'(overflow), 0);

    // Clear with a same-cycle pop.
    push(9'h050, 1); push(9'h060, 1);
    acc_clr = 1'b1; out_ready = 1'b1; step(); acc_clr = 1'b0; out_ready = 1'b0;
    chk("clr_pop_acc", 32'(acc_total), 0);
    chk("clr_pop_level", 32'(level), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("acc_60", 32'(acc_total), 32'h060);

    // Asynchronous reset mid-stream.
    push(9'd1, 1); push(9'd2, 1); push(9'd3, 1);
    chk("lvl3_pre_rst", 32'(level), 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_level", 32'(level), 0);
    chk("async_acc", 32'(acc_total), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push(9'h042, 1);
    chk("post_rst_level", 32'(level), 1);
    chk("post_rst_data", 32'(out_data), 32'h042);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("post_rst_acc", 32'(acc_total), 32'h042);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
